// File: rtl/vga_frame_buffer_ctrl.sv
// Double-buffer controller: swaps front/back framebuffer bases on a vsync edge
// and, when VGA_FB_CLEAR_EN is defined, clears the back buffer through a RAM write port.
module vga_frame_buffer_ctrl #(
  parameter int FRAME_PIXELS = 307200,
  parameter int ADDR_W       = 20,
  parameter int DATA_W       = 24,
  parameter int VSYNC_ACTIVE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vga_vsync,
  output logic [ADDR_W-1:0] front_offset,
  output logic [ADDR_W-1:0] back_offset,
  output logic              front_sel,
  input  logic              swap_req,
  output logic              swap_ack,
  input  logic              clear_start,
  input  logic [DATA_W-1:0] clear_color,
  output logic              clear_busy,
  output logic              clear_done,
  output logic [ADDR_W-1:0] wr_address,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_enable,
  input  logic              wr_ready,
  output logic [15:0]       frame_count
);

  localparam logic [ADDR_W-1:0] FRAME_SIZE = ADDR_W'(FRAME_PIXELS);
  localparam logic              VS_ACT     = 1'(VSYNC_ACTIVE);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
`ifdef VGA_FB_CLEAR_EN
    CLEAR     = 2'd1,
`endif
    SWAP_WAIT = 2'd2
  } state_t;

  state_t state;
  logic   vs_sync_p0;
  logic   vs_sync_p1;
  logic   vs_prev_p2;
  logic   vs_edge;

  // Stage boundary: two-flop synchronizer, then a registered active-edge detector
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_sync_p0 <= ~VS_ACT;
      vs_sync_p1 <= ~VS_ACT;
      vs_prev_p2 <= ~VS_ACT;
      vs_edge    <= 1'b0;
    end else begin
      vs_sync_p0 <= vga_vsync;
      vs_sync_p1 <= vs_sync_p0;
      vs_prev_p2 <= vs_sync_p1;
      vs_edge    <= (vs_sync_p1 == VS_ACT) && (vs_prev_p2 != VS_ACT);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_count <= 16'd0;
    end else if (vs_edge) begin
      frame_count <= frame_count + 16'd1;
    end
  end

`ifdef VGA_FB_CLEAR_EN
  logic              swap_pending;
  logic [ADDR_W-1:0] clear_last;

  // Back buffer cannot move during a clear, so its last address is stable
  assign clear_last = back_offset + FRAME_SIZE - ADDR_W'(1);
`else
  logic unused_clear;

  assign unused_clear = ^{clear_start, clear_color, wr_ready};
  assign clear_busy   = 1'b0;
  assign clear_done   = 1'b0;
  assign wr_enable    = 1'b0;
  assign wr_address   = '0;
  assign wr_data      = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      front_sel    <= 1'b0;
      front_offset <= '0;
      back_offset  <= FRAME_SIZE;
      swap_ack     <= 1'b0;
`ifdef VGA_FB_CLEAR_EN
      swap_pending <= 1'b0;
      wr_enable    <= 1'b0;
      wr_address   <= '0;
      wr_data      <= '0;
      clear_busy   <= 1'b0;
      clear_done   <= 1'b0;
`endif
    end else begin
      swap_ack <= 1'b0;
`ifdef VGA_FB_CLEAR_EN
      clear_done <= 1'b0;
`endif
      case (state)
        IDLE: begin
`ifdef VGA_FB_CLEAR_EN
          if (clear_start) begin
            state        <= CLEAR;
            wr_data      <= clear_color;
            wr_address   <= back_offset;
            clear_busy   <= 1'b1;
            swap_pending <= swap_req;
          end else
`endif
          if (swap_req) begin
            state <= SWAP_WAIT;
          end
        end
`ifdef VGA_FB_CLEAR_EN
        CLEAR: begin
          if (swap_req) begin
            swap_pending <= 1'b1;
          end
          // First CLEAR cycle only raises the write request
          if (!wr_enable) begin
            wr_enable <= 1'b1;
          end else if (wr_ready) begin
            if (wr_address == clear_last) begin
              wr_enable  <= 1'b0;
              clear_busy <= 1'b0;
              clear_done <= 1'b1;
              state      <= (swap_pending || swap_req) ? SWAP_WAIT : IDLE;
            end else begin
              wr_address <= wr_address + ADDR_W'(1);
            end
          end
        end
`endif
        SWAP_WAIT: begin
          if (vs_edge) begin
            front_sel    <= ~front_sel;
            front_offset <= back_offset;
            back_offset  <= front_offset;
            swap_ack     <= 1'b1;
`ifdef VGA_FB_CLEAR_EN
            swap_pending <= 1'b0;
`endif
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_frame_buffer_ctrl.sv
// Bench for vga_frame_buffer_ctrl (FRAME_PIXELS=16); covers both VGA_FB_CLEAR_EN builds.
module tb_vga_frame_buffer_ctrl;
  localparam int FP = 16;
  localparam int AW = 20;
  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic          vga_vsync;
  logic          swap_req;
  logic          clear_start;
  logic          wr_ready;
  logic [DW-1:0] clear_color;
  logic [AW-1:0] front_offset;
  logic [AW-1:0] back_offset;
  logic [AW-1:0] wr_address;
  logic [DW-1:0] wr_data;
  logic          front_sel;
  logic          swap_ack;
  logic          clear_busy;
  logic          clear_done;
  logic          wr_enable;
  logic [15:0]   frame_count;

  int checks = 0;
  int errors = 0;
  int mfront = 0;
  int mframes = 0;
  int mswaps = 0;
  int ready_mode = 0;
  int rdy_cyc = 0;
  int done_cnt = 0;
  int ack_cnt = 0;
  int en_seen = 0;
  int stall_cnt = 0;
  bit prev_stall = 1'b0;
  logic [AW-1:0] stall_addr;
  logic [DW-1:0] stall_data;
  logic [AW-1:0] wr_addr_q[$];
  logic [DW-1:0] wr_data_q[$];
  logic [DW-1:0] color;
`ifdef VGA_FB_CLEAR_EN
  int base;
  int done0;
  int stall0;
`endif

  vga_frame_buffer_ctrl #(
    .FRAME_PIXELS(FP),
    .ADDR_W(AW),
    .DATA_W(DW),
    .VSYNC_ACTIVE(0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .vga_vsync(vga_vsync),
    .front_offset(front_offset),
    .back_offset(back_offset),
    .front_sel(front_sel),
    .swap_req(swap_req),
    .swap_ack(swap_ack),
    .clear_start(clear_start),
    .clear_color(clear_color),
    .clear_busy(clear_busy),
    .clear_done(clear_done),
    .wr_address(wr_address),
    .wr_data(wr_data),
    .wr_enable(wr_enable),
    .wr_ready(wr_ready),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_offsets(input string tag);
    check_eq({tag, "_sel"}, 32'(front_sel), mfront);
    check_eq({tag, "_front"}, 32'(front_offset), (mfront != 0) ? FP : 0);
    check_eq({tag, "_back"}, 32'(back_offset), (mfront != 0) ? 0 : FP);
  endtask

  // Drive vsync active; the swap (if any) must land exactly three edges later
  task automatic vs_assert(input bit expect_swap);
    vga_vsync = 1'b0;
    mframes++;
    tick(3);
    check_offsets("pre_swap");
    check_eq("pre_frame_count", 32'(frame_count), mframes - 1);
    check_eq("pre_swap_ack", 32'(swap_ack), 0);
    tick(1);
    if (expect_swap) begin
      mfront = 1 - mfront;
      mswaps++;
    end
    check_offsets("swap");
    check_eq("swap_ack", 32'(swap_ack), 32'(expect_swap));
    check_eq("frame_count", 32'(frame_count), mframes);
    if (expect_swap) swap_req = 1'b0;
    tick(1);
    check_eq("swap_ack_width", 32'(swap_ack), 0);
  endtask

  task automatic vs_release();
    tick(1 + int'($urandom_range(0, 3)));
    vga_vsync = 1'b1;
    tick(2 + int'($urandom_range(0, 2)));
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 400) begin
      tick(1);
      n++;
    end
    check_eq("clear_done_seen", 32'(done_cnt >= target), 1);
  endtask

  task automatic wait_writes(input int k);
    int n = 0;
    while (wr_addr_q.size() < k && n < 200) begin
      tick(1);
      n++;
    end
    check_eq("writes_seen", 32'(wr_addr_q.size() >= k), 1);
  endtask

  task automatic check_clear(input string tag, input int base_a, input logic [DW-1:0] col);
    check_eq({tag, "_count"}, 32'(wr_addr_q.size()), FP);
    foreach (wr_addr_q[i]) begin
      check_eq({tag, "_addr"}, 32'(wr_addr_q[i]), base_a + i);
      check_eq({tag, "_data"}, 32'(wr_data_q[i]), 32'(col));
    end
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  // Called #1 after an edge: reset lands mid-cycle and must act before the next edge
  task automatic async_reset_check(input string tag);
    #2;
    rst = 1'b1;
    #1;
    mfront = 0;
    mframes = 0;
    check_offsets(tag);
    check_eq({tag, "_frame_count"}, 32'(frame_count), 0);
    check_eq({tag, "_wr_enable"}, 32'(wr_enable), 0);
    check_eq({tag, "_wr_address"}, 32'(wr_address), 0);
    check_eq({tag, "_wr_data"}, 32'(wr_data), 0);
    check_eq({tag, "_clear_busy"}, 32'(clear_busy), 0);
    check_eq({tag, "_clear_done"}, 32'(clear_done), 0);
    check_eq({tag, "_swap_ack"}, 32'(swap_ack), 0);
    tick(1);
    swap_req = 1'b0;
    clear_start = 1'b0;
    rst = 1'b0;
    wr_addr_q.delete();
    wr_data_q.delete();
    tick(1);
  endtask

  initial begin
    wr_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rdy_cyc++;
      case (ready_mode)
        1:       wr_ready = (rdy_cyc % 3) != 0;
        2:       wr_ready = $urandom_range(0, 3) != 0;
        default: wr_ready = 1'b1;
      endcase
    end
  end

  // Monitor on the falling edge: records writes accepted at the next rising edge
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check_eq("stall_enable", 32'(wr_enable), 1);
          check_eq("stall_addr", 32'(wr_address), 32'(stall_addr));
          check_eq("stall_data", 32'(wr_data), 32'(stall_data));
        end
        prev_stall = wr_enable && !wr_ready;
        if (prev_stall) stall_cnt++;
        stall_addr = wr_address;
        stall_data = wr_data;
        if (wr_enable) en_seen++;
        if (wr_enable && wr_ready) begin
          wr_addr_q.push_back(wr_address);
          wr_data_q.push_back(wr_data);
        end
        if (clear_done) begin
          done_cnt++;
          check_eq("done_vs_busy", 32'({clear_busy, wr_enable}), 0);
        end
        if (swap_ack) ack_cnt++;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    vga_vsync = 1'b1;
    swap_req = 1'b0;
    clear_start = 1'b0;
    clear_color = '0;
    tick(3);
    check_offsets("rst");
    check_eq("rst_frame_count", 32'(frame_count), 0);
    check_eq("rst_wr_enable", 32'(wr_enable), 0);
    check_eq("rst_wr_address", 32'(wr_address), 0);
    check_eq("rst_wr_data", 32'(wr_data), 0);
    check_eq("rst_clear_busy", 32'(clear_busy), 0);
    check_eq("rst_clear_done", 32'(clear_done), 0);
    check_eq("rst_swap_ack", 32'(swap_ack), 0);
    rst = 1'b0;
    tick(2);

    swap_req = 1'b1;
    tick(1 + int'($urandom_range(0, 3)));
    vs_assert(1'b1);
    vs_release();
    vs_assert(1'b0);
    vs_release();

`ifdef VGA_FB_CLEAR_EN
    // Unstalled clear: exact latency and throughput
    ready_mode = 0;
    tick(1);
    color = DW'($urandom);
    base = (mfront != 0) ? 0 : FP;
    done0 = done_cnt;
    clear_color = color;
    clear_start = 1'b1;
    tick(1);
    clear_start = 1'b0;
    check_eq("k0_busy", 32'(clear_busy), 1);
    check_eq("k0_wr_enable", 32'(wr_enable), 0);
    tick(1);
    check_eq("k1_wr_enable", 32'(wr_enable), 1);
    check_eq("k1_wr_address", 32'(wr_address), base);
    check_eq("k1_wr_data", 32'(wr_data), 32'(color));
    tick(15);
    check_eq("k16_wr_enable", 32'(wr_enable), 1);
    check_eq("k16_clear_done", 32'(clear_done), 0);
    check_eq("k16_wr_address", 32'(wr_address), base + FP - 1);
    tick(1);
    check_eq("k17_clear_done", 32'(clear_done), 1);
    check_eq("k17_busy", 32'(clear_busy), 0);
    check_eq("k17_wr_enable", 32'(wr_enable), 0);
    tick(1);
    check_eq("k18_clear_done", 32'(clear_done), 0);
    check_eq("fast_done_count", 32'(done_cnt), done0 + 1);
    check_clear("clr_fast", base, color);

    // Every third cycle stalled
    ready_mode = 1;
    color = 24'hABCDEF;
    base = (mfront != 0) ? 0 : FP;
    done0 = done_cnt;
    stall0 = stall_cnt;
    clear_color = color;
    clear_start = 1'b1;
    tick(1);
    clear_start = 1'b0;
    clear_color = DW'($urandom);
    wait_done(done0 + 1);
    tick(3);
    check_eq("stall_done_count", 32'(done_cnt), done0 + 1);
    check_eq("stalls_happened", 32'(stall_cnt > stall0), 1);
    check_clear("clr_stall", base, color);

    // Swap requested and vsync seen mid-clear: deferred to the first edge after the clear
    ready_mode = 2;
    color = DW'($urandom);
    base = (mfront != 0) ? 0 : FP;
    done0 = done_cnt;
    clear_color = color;
    clear_start = 1'b1;
    tick(1);
    clear_start = 1'b0;
    wait_writes(4);
    swap_req = 1'b1;
    vs_assert(1'b0);
    check_eq("busy_during_vs", 32'(clear_busy), 1);
    vs_release();
    wait_done(done0 + 1);
    check_offsets("after_clear");
    check_clear("clr_swap", base, color);
    tick(2);
    check_offsets("pending_hold");
    vs_assert(1'b1);
    vs_release();

    // Clear and swap in the same cycle, plus an ignored second clear
    color = DW'($urandom);
    base = (mfront != 0) ? 0 : FP;
    done0 = done_cnt;
    clear_color = color;
    swap_req = 1'b1;
    clear_start = 1'b1;
    tick(1);
    clear_start = 1'b0;
    check_eq("simul_busy", 32'(clear_busy), 1);
    check_offsets("simul_start");
    tick(3 + int'($urandom_range(0, 3)));
    clear_color = DW'($urandom);
    clear_start = 1'b1;
    tick(1);
    clear_start = 1'b0;
    wait_done(done0 + 1);
    check_clear("clr_simul", base, color);
    clear_start = 1'b1;
    tick(1);
    clear_start = 1'b0;
    tick(20);
    check_eq("ignored_writes", 32'(wr_addr_q.size()), 0);
    check_eq("ignored_done", 32'(done_cnt), done0 + 1);
    check_offsets("simul_hold");
    vs_assert(1'b1);
    vs_release();

    // Reset aborts a clear in progress
    ready_mode = 1;
    clear_color = DW'($urandom);
    clear_start = 1'b1;
    tick(1);
    clear_start = 1'b0;
    tick(6);
    check_eq("pre_abort_wr_enable", 32'(wr_enable), 1);
    async_reset_check("rst_clear");
    check_eq("wr_enable_seen", 32'(en_seen > 0), 1);
`else
    // Clear engine absent: clear_start has no effect and does not block swaps
    ready_mode = 2;
    color = DW'($urandom);
    clear_color = color;
    clear_start = 1'b1;
    tick(1);
    clear_start = 1'b0;
    tick(40);
    check_eq("off_writes", 32'(wr_addr_q.size()), 0);
    check_eq("off_wr_enable_seen", 32'(en_seen), 0);
    check_eq("off_done_count", 32'(done_cnt), 0);
    check_eq("off_busy", 32'(clear_busy), 0);
    check_eq("off_wr_address", 32'(wr_address), 0);
    check_eq("off_wr_data", 32'(wr_data), 0);
    swap_req = 1'b1;
    clear_start = 1'b1;
    tick(1);
    clear_start = 1'b0;
    tick(1);
    vs_assert(1'b1);
    vs_release();
`endif

    // Reset aborts a pending swap wait
    swap_req = 1'b1;
    tick(2);
    vs_assert(1'b1);
    vs_release();
    swap_req = 1'b1;
    tick(2);
    async_reset_check("rst_swapwait");
    tick(4);
    check_offsets("post_rst_idle");

    swap_req = 1'b1;
    tick(2);
    vs_assert(1'b1);
    vs_release();
    check_eq("swap_ack_total", 32'(ack_cnt), mswaps);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_frame_buffer_ctrl.md
# vga_frame_buffer_ctrl

Double-buffer controller sitting directly upstream of the VGA scan-out stage. It owns the front/back framebuffer split in the shared 20-bit pixel RAM and drives the front-buffer base offset that the scan-out reader adds to its pixel id. It swaps buffers only at a vertical-sync boundary, on request from the renderer. It can also clear the back buffer to a fill colour through a RAM write port.

## Interface
Parameters:
- FRAME_PIXELS, 307200 — pixels per buffer (640×480); buffer 1 base = FRAME_PIXELS
- ADDR_W, 20 — RAM address width
- DATA_W, 24 — RAM data width
- VSYNC_ACTIVE, 0 — active level of vga_vsync (480p timing uses active-low)

Ports (clock is `clk`, reset is `rst`; reset is asynchronous and active-high):
- clk  in  1  system clock (100 MHz)
- rst  in  1  asynchronous, active-high reset
- vga_vsync  in  1  vertical sync from the pixel-clock domain; asynchronous to clk
- front_offset  out  ADDR_W  front-buffer base address, fed to the scan-out stage
- back_offset  out  ADDR_W  back-buffer base address, fed to the renderer
- front_sel  out  1  0: buffer 0 is front; 1: buffer 1 is front
- swap_req  in  1  level; renderer requests a swap at the next frame boundary
- swap_ack  out  1  1-cycle pulse when a swap takes effect
- clear_start  in  1  1-cycle pulse; fill the back buffer with clear_color
- clear_color  in  DATA_W  fill value, sampled on an accepted clear_start
- clear_busy  out  1  high while a clear is in progress
- clear_done  out  1  1-cycle pulse after the last clear write is accepted
- wr_address  out  ADDR_W  RAM write address
- wr_data  out  DATA_W  RAM write data
- wr_enable  out  1  RAM write request
- wr_ready  in  1  RAM accepts the write this cycle when wr_enable && wr_ready
- frame_count  out  16  count of vsync-active edges, wraps at 65535→0

## Operation
- vga_vsync passes through a 2-flop synchronizer, then an edge detector. The detector fires `vs_edge` for one cycle when the synchronized signal transitions to VSYNC_ACTIVE.
- Offsets:
  - front_sel=0: front_offset=0, back_offset=FRAME_PIXELS.
  - front_sel=1: the two values are swapped.
  - Both offsets are registered and change in the same cycle as front_sel.
- frame_count increments on every vs_edge, independent of FSM state.
- FSM states are IDLE, CLEAR and SWAP_WAIT.
- IDLE:
  - clear_start → CLEAR. clear_color is latched, wr_address = back_offset, clear_busy=1.
  - Else swap_req → SWAP_WAIT.
  - If both are asserted in the same cycle, clear_start wins and the swap is recorded as pending.
- CLEAR:
  - wr_enable=1 and wr_data = latched colour.
  - On each cycle with wr_ready, wr_address increments.
  - swap_req seen in any CLEAR cycle sets `swap_pending`.
  - When the write at back_offset+FRAME_PIXELS−1 is accepted: wr_enable=0, clear_busy=0 and clear_done=1 on the next cycle. The FSM then goes to SWAP_WAIT if swap_pending, else IDLE.
  - clear_start during CLEAR or SWAP_WAIT is ignored.
- SWAP_WAIT:
  - On vs_edge: front_sel toggles, swap_ack pulses, swap_pending clears, → IDLE.
  - A swap never occurs mid-frame and never occurs during a clear.
- swap_req held high after swap_ack re-requests a swap. The renderer drops it on swap_ack.
- Address arithmetic is ADDR_W-bit unsigned. Requirement: 2·FRAME_PIXELS ≤ 2^ADDR_W.

## Timing
- Reset values:
  - front_sel=0, front_offset=0, back_offset=FRAME_PIXELS.
  - wr_enable=0, wr_address=0, wr_data=0.
  - swap_ack=0, clear_busy=0, clear_done=0, frame_count=0.
  - Synchronizer flops = inactive vsync level; state=IDLE; swap_pending=0.
- Reset asserted mid-clear or mid-swap-wait aborts immediately to the reset values above.
- vsync latency: vga_vsync reaches its active level before clk edge N (setup met). Then vs_edge is high in the cycle after edge N+2, and front_sel/offsets/swap_ack update at edge N+3.
- Clear start: clear_start sampled at edge K → first wr_enable=1 after edge K+1.
- Clear throughput: with wr_ready tied high, the clear takes exactly FRAME_PIXELS cycles, and clear_done is high after edge K+1+FRAME_PIXELS.
- Stalls: wr_ready low holds wr_address and wr_data stable with wr_enable high.
- clear_busy and the final wr_enable fall in the same cycle that clear_done rises.

## Configuration
- VGA_FB_CLEAR_EN defined: the clear engine and the CLEAR state are compiled in, as described above.
- VGA_FB_CLEAR_EN undefined:
  - No CLEAR state; clear_start is ignored.
  - clear_busy, clear_done and wr_enable are tied 0.
  - wr_address and wr_data are tied 0.
  - Swap and frame-count behaviour are unchanged.

## Test plan
All scenarios use FRAME_PIXELS=16.
- Reset: assert rst asynchronously mid-cycle → all outputs take their reset values immediately; back_offset=16.
- Swap: swap_req=1 in IDLE, vsync active at edge N → front_sel=1, front_offset=16, back_offset=0 and a 1-cycle swap_ack at edge N+3; frame_count=1.
- Clear with stalls: clear_start, clear_color=24'hABCDEF, wr_ready low every 3rd cycle → 16 accepted writes at addresses 16..31 with data ABCDEF; address held during stalls; one clear_done pulse.
- Swap during clear: swap_req raised during the 5th write, vsync edge during the clear → no swap; the swap happens at the first vs_edge after clear_done.
- Simultaneous and ignored requests:
  - clear_start with swap_req in the same IDLE cycle → clear runs first, then the swap.
  - A second clear_start while busy → ignored; write count stays at 16.
- Macro off (VGA_FB_CLEAR_EN undefined): clear_start pulse → wr_enable never rises, clear_done never pulses; swap scenario still passes.
